// File: rtl/ivs_axi_rd_dma.sv
// AXI4 read master: splits a command into 4 KB-safe bursts and streams R data out through a FWFT FIFO.
// Optional: IVS_RD_DMA_ERR_ABORT_EN stops issuing bursts after the first errored beat.
module ivs_axi_rd_dma #(
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [3:0]  AXI_ID     = 4'h1
) (
  input  logic         aclk,
  input  logic         arst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [31:0]  cmd_addr,
  input  logic [15:0]  cmd_beats,
  output logic         arvalid,
  input  logic         arready,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [5:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  input  logic         rvalid,
  output logic         rready,
  input  logic [3:0]   rid,
  input  logic [127:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [127:0] dout_data,
  output logic         dout_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_DONE} state_e;

  state_e       state_q;
  logic [31:0]  addr_q;
  logic [15:0]  rem_q;
  logic [6:0]   bc_q;
  logic         arvalid_q;
  logic [31:0]  araddr_q;
  logic [5:0]   arlen_q;
  logic         done_q;
  logic         err_q;
`ifdef IVS_RD_DMA_ERR_ABORT_EN
  logic         abort_q;
  logic         abort_now;
`endif

  logic [128:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  logic        fifo_full, fifo_empty, r_hs, pop, beat_err, burst_end, push_last;
  logic [16:0] bnd, len17;
  logic [6:0]  len_c, burst_len;

  // Burst length limited by remaining beats, MAX_BURST and the distance to the next 4 KB page.
  always_comb begin
    bnd   = 17'd256 - {8'd0, addr_q[11:4]};
    len17 = {1'b0, rem_q};
    if (len17 > 17'(MAX_BURST)) len17 = 17'(MAX_BURST);
    if (len17 > bnd)            len17 = bnd;
    len_c = len17[6:0];
  end

  assign burst_len  = {1'b0, arlen_q} + 7'd1;
  assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign rready     = (state_q == S_DATA) && !fifo_full;
  assign r_hs       = rvalid && rready;
  assign dout_valid = !fifo_empty;
  assign pop        = dout_valid && dout_ready;
  assign beat_err   = (rresp != 2'b00) || (rid != AXI_ID) || ((bc_q == 7'd1) ? !rlast : rlast);
  assign burst_end  = r_hs && (bc_q == 7'd1);

`ifdef IVS_RD_DMA_ERR_ABORT_EN
  assign abort_now  = abort_q || beat_err;
  assign push_last  = burst_end && ((rem_q == '0) || abort_now);
`else
  assign push_last  = burst_end && (rem_q == '0);
`endif

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      bc_q      <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IVS_RD_DMA_ERR_ABORT_EN
      abort_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (cmd_valid) begin
          addr_q  <= {cmd_addr[31:4], 4'h0};
          rem_q   <= cmd_beats;
          err_q   <= 1'b0;
`ifdef IVS_RD_DMA_ERR_ABORT_EN
          abort_q <= 1'b0;
`endif
          state_q <= (cmd_beats == '0) ? S_DONE : S_ADDR;
        end
        S_ADDR: if (!arvalid_q) begin
          arvalid_q <= 1'b1;
          araddr_q  <= addr_q;
          arlen_q   <= 6'(len_c - 7'd1);
        end else if (arready) begin
          arvalid_q <= 1'b0;
          addr_q    <= addr_q + {21'd0, burst_len, 4'h0};
          rem_q     <= rem_q - {9'd0, burst_len};
          bc_q      <= burst_len;
          state_q   <= S_DATA;
        end
        S_DATA: if (r_hs) begin
          bc_q <= bc_q - 7'd1;
          if (beat_err) err_q <= 1'b1;
`ifdef IVS_RD_DMA_ERR_ABORT_EN
          if (beat_err) abort_q <= 1'b1;
          // The errored burst still runs to its last beat; only later bursts are dropped.
          if (bc_q == 7'd1) begin
            if (abort_now) begin
              rem_q   <= '0;
              state_q <= S_DRAIN;
            end else begin
              state_q <= (rem_q != '0) ? S_ADDR : S_DRAIN;
            end
          end
`else
          if (bc_q == 7'd1) state_q <= (rem_q != '0) ? S_ADDR : S_DRAIN;
`endif
        end
        S_DRAIN: if (fifo_empty) state_q <= S_DONE;
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (r_hs) mem_q[wptr_q] <= {push_last, rdata};
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (r_hs) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({r_hs, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_data = dout_valid ? mem_q[rptr_q][127:0] : '0;
  assign dout_last = dout_valid && mem_q[rptr_q][128];
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arid      = AXI_ID;
  assign arsize    = 3'b100;
  assign arburst   = 2'b01;

endmodule

// File: tb/tb_ivs_axi_rd_dma.sv
// Directed bench for ivs_axi_rd_dma with a single-outstanding AXI read memory model.
module tb_ivs_axi_rd_dma;

  logic         aclk = 1'b0;
  logic         arst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_addr;
  logic [15:0]  cmd_beats;
  logic         arvalid;
  logic         arready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [5:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         dout_valid;
  logic         dout_ready;
  logic [127:0] dout_data;
  logic         dout_last;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  logic [31:0]  ar_addr_log [$];
  logic [5:0]   ar_len_log  [$];
  logic [128:0] dout_log    [$];
  int done_cnt   = 0;
  int r_accepted = 0;
  int m_burst    = 0;
  int err_burst  = -1;
  int err_beat   = -1;

  ivs_axi_rd_dma #(.MAX_BURST(64), .FIFO_DEPTH(16), .AXI_ID(4'h1)) dut (
    .aclk(aclk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, ~a, a + 32'h11, a};
  endfunction

  // Memory model: handshakes are predicted on the falling edge, drives change 1 ns after the rising edge.
  initial begin : mem_model
    logic        ar_hs, r_hs;
    logic [31:0] cap_addr, m_addr;
    logic [5:0]  cap_len;
    int          m_left, m_beat;
    m_addr = '0; m_left = 0; m_beat = 0;
    arready = 1'b1; rvalid = 1'b0; rid = 4'h1; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    forever begin
      @(negedge aclk);
      ar_hs = arvalid && arready; cap_addr = araddr; cap_len = arlen;
      r_hs  = rvalid && rready;
      @(posedge aclk); #1;
      if (!arst_n) begin
        m_left = 0;
      end else begin
        if (r_hs) begin
          r_accepted++; m_beat++; m_left--;
          if (m_left == 0) m_burst++;
        end
        if (ar_hs) begin
          ar_addr_log.push_back(cap_addr);
          ar_len_log.push_back(cap_len);
          m_addr = cap_addr; m_left = int'(cap_len) + 1; m_beat = 0;
        end
      end
      rvalid = (m_left > 0);
      rdata  = pat(m_addr + 32'(m_beat) * 32'd16);
      rlast  = (m_left == 1);
      rresp  = (m_burst == err_burst && m_beat == err_beat) ? 2'b10 : 2'b00;
    end
  end

  always @(negedge aclk) begin
    if (dout_valid && dout_ready) dout_log.push_back({dout_last, dout_data});
    if (done) done_cnt++;
  end

  task automatic clear_logs();
    ar_addr_log.delete(); ar_len_log.delete(); dout_log.delete();
    done_cnt = 0; r_accepted = 0; m_burst = 0;
  endtask

  task automatic start_cmd(input logic [31:0] a, input logic [15:0] n);
    bit ok = 0;
    @(posedge aclk); #1;
    cmd_addr = a; cmd_beats = n; cmd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL cmd_accept: cmd_ready=%0b required 1 within 200 cycles", cmd_ready); end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    bit seen = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge aclk);
      if (done) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout: done=%0b required 1 within %0d cycles", done, lim); end
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_reset();
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; dout_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 arst_n = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if ({cmd_ready, busy, done, err, arvalid, rready, dout_valid, dout_last} !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_ctrl: got %b required 10000000", {cmd_ready, busy, done, err, arvalid, rready, dout_valid, dout_last});
    end
    checks++;
    if (araddr !== 32'h0 || arlen !== 6'h0 || dout_data !== 128'h0) begin
      errors++; $display("FAIL reset_data: araddr=%h arlen=%0d dout=%h required 0", araddr, arlen, dout_data);
    end
    checks++;
    if (arid !== 4'h1 || arsize !== 3'b100 || arburst !== 2'b01) begin
      errors++; $display("FAIL ar_const: arid=%h arsize=%b arburst=%b required 1/100/01", arid, arsize, arburst);
    end
  endtask

  task automatic test_single();
    clear_logs();
    start_cmd(32'h1000, 16);
    checks++;
    if (arvalid !== 1'b0) begin errors++; $display("FAIL ar_delay: arvalid=%b required 0", arvalid); end
    @(posedge aclk); #1;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h1000 || arlen !== 6'd15) begin
      errors++; $display("FAIL ar_issue: arvalid=%b araddr=%h arlen=%0d required 1/00001000/15", arvalid, araddr, arlen);
    end
    wait_done(500);
    checks++;
    if (ar_addr_log.size() != 1) begin errors++; $display("FAIL single_ar_count: got %0d required 1", ar_addr_log.size()); end
    checks++;
    if (dout_log.size() != 16) begin errors++; $display("FAIL single_beats: got %0d required 16", dout_log.size()); end
    for (int i = 0; i < dout_log.size(); i++) begin
      checks++;
      if (dout_log[i] !== {1'(i == 15), pat(32'h1000 + 32'(i) * 32'd16)}) begin
        errors++; $display("FAIL single_beat%0d: got %h required %h", i, dout_log[i], {1'(i == 15), pat(32'h1000 + 32'(i) * 32'd16)});
      end
    end
    checks++;
    if (done_cnt != 1 || err !== 1'b0) begin errors++; $display("FAIL single_done_err: done_cnt=%0d err=%b required 1/0", done_cnt, err); end
  endtask

  task automatic test_bursts(input logic [31:0] base, input logic [15:0] n, input int nar,
                             input logic [31:0] ea0, input logic [5:0] el0,
                             input logic [31:0] ea1, input logic [5:0] el1,
                             input logic [31:0] ea2, input logic [5:0] el2);
    logic [31:0] ea [3];
    logic [5:0]  el [3];
    ea = '{ea0, ea1, ea2}; el = '{el0, el1, el2};
    clear_logs();
    start_cmd(base, n);
    wait_done(2000);
    checks++;
    if (ar_addr_log.size() != nar) begin errors++; $display("FAIL burst_count@%h: got %0d required %0d", base, ar_addr_log.size(), nar); end
    for (int j = 0; j < ar_addr_log.size() && j < 3; j++) begin
      checks++;
      if (ar_addr_log[j] !== ea[j] || ar_len_log[j] !== el[j]) begin
        errors++; $display("FAIL burst%0d@%h: araddr=%h arlen=%0d required %h/%0d", j, base, ar_addr_log[j], ar_len_log[j], ea[j], el[j]);
      end
    end
    checks++;
    if (dout_log.size() != int'(n)) begin errors++; $display("FAIL burst_beats@%h: got %0d required %0d", base, dout_log.size(), n); end
    for (int i = 0; i < dout_log.size(); i++) begin
      checks++;
      if (dout_log[i] !== {1'(i == int'(n) - 1), pat({base[31:4], 4'h0} + 32'(i) * 32'd16)}) begin
        errors++; $display("FAIL burst_beat%0d@%h: got %h", i, base, dout_log[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL burst_done@%h: done_cnt=%0d required 1", base, done_cnt); end
  endtask

  task automatic test_backpressure();
    clear_logs();
    dout_ready = 1'b0;
    start_cmd(32'h300A, 32);
    repeat (40) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (r_accepted != 16 || rready !== 1'b0 || dout_valid !== 1'b1 || dout_log.size() != 0) begin
      errors++; $display("FAIL bp_full: accepted=%0d rready=%b dout_valid=%b popped=%0d required 16/0/1/0",
                         r_accepted, rready, dout_valid, dout_log.size());
    end
    dout_ready = 1'b1;
    wait_done(500);
    checks++;
    if (ar_addr_log.size() != 1 || ar_addr_log[0] !== 32'h3000 || ar_len_log[0] !== 6'd31) begin
      errors++; $display("FAIL bp_ar: count=%0d required one AR 00003000/31", ar_addr_log.size());
    end
    checks++;
    if (dout_log.size() != 32) begin errors++; $display("FAIL bp_beats: got %0d required 32", dout_log.size()); end
    for (int i = 0; i < dout_log.size(); i++) begin
      checks++;
      if (dout_log[i] !== {1'(i == 31), pat(32'h3000 + 32'(i) * 32'd16)}) begin
        errors++; $display("FAIL bp_beat%0d: got %h required %h", i, dout_log[i], {1'(i == 31), pat(32'h3000 + 32'(i) * 32'd16)});
      end
    end
  endtask

  task automatic test_zero_beats();
    clear_logs();
    start_cmd(32'h40, 0);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_c1: done=%b cmd_ready=%b busy=%b required 0/0/1", done, cmd_ready, busy);
    end
    @(posedge aclk); #1;
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_c2: done=%b cmd_ready=%b busy=%b required 1/1/0", done, cmd_ready, busy);
    end
    @(posedge aclk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_pulse: done=%b required 0", done); end
    repeat (3) @(posedge aclk);
    checks++;
    if (ar_addr_log.size() != 0 || dout_log.size() != 0) begin
      errors++; $display("FAIL zero_traffic: ars=%0d beats=%0d required 0/0", ar_addr_log.size(), dout_log.size());
    end
  endtask

  task automatic test_error();
    int nexp, nar;
`ifdef IVS_RD_DMA_ERR_ABORT_EN
    nexp = 8;  nar = 1;
`else
    nexp = 20; nar = 2;
`endif
    clear_logs();
    err_burst = 0; err_beat = 2;
    start_cmd(32'h1F80, 20);
    wait_done(1000);
    err_burst = -1; err_beat = -1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_flag: err=%b required 1", err); end
    checks++;
    if (ar_addr_log.size() != nar) begin errors++; $display("FAIL err_ar_count: got %0d required %0d", ar_addr_log.size(), nar); end
    checks++;
    if (dout_log.size() != nexp) begin errors++; $display("FAIL err_beats: got %0d required %0d", dout_log.size(), nexp); end
    for (int i = 0; i < dout_log.size(); i++) begin
      checks++;
      if (dout_log[i] !== {1'(i == nexp - 1), pat(32'h1F80 + 32'(i) * 32'd16)}) begin
        errors++; $display("FAIL err_beat%0d: got %h required %h", i, dout_log[i], {1'(i == nexp - 1), pat(32'h1F80 + 32'(i) * 32'd16)});
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL err_done: done_cnt=%0d required 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    start_cmd(32'h5000, 4);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%b required 0", err); end
    wait_done(300);
    start_cmd(32'h5040, 3);
    wait_done(300);
    checks++;
    if (dout_log.size() != 7 || done_cnt != 2) begin
      errors++; $display("FAIL b2b_count: beats=%0d done_cnt=%0d required 7/2", dout_log.size(), done_cnt);
    end
    for (int i = 0; i < dout_log.size(); i++) begin
      checks++;
      if (dout_log[i] !== {1'(i == 3 || i == 6), pat(32'h5000 + 32'(i) * 32'd16)}) begin
        errors++; $display("FAIL b2b_beat%0d: got %h", i, dout_log[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_logs();
    dout_ready = 1'b0;
    start_cmd(32'h6000, 32);
    repeat (10) @(posedge aclk);
    #1 arst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || dout_valid !== 1'b0 || rready !== 1'b0 || arvalid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: busy=%b cmd_ready=%b dout_valid=%b rready=%b arvalid=%b required 0/1/0/0/0",
                         busy, cmd_ready, dout_valid, rready, arvalid);
    end
    repeat (3) @(posedge aclk);
    #1 arst_n = 1'b1;
    dout_ready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (rready !== 1'b0 || dout_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset: rready=%b dout_valid=%b cmd_ready=%b required 0/0/1", rready, dout_valid, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bursts(32'h1F80, 20,  2, 32'h1F80, 6'd7,  32'h2000, 6'd11, 32'h0, 6'd0);
    test_bursts(32'h0,    150, 3, 32'h0,    6'd63, 32'h400,  6'd63, 32'h800, 6'd21);
    test_backpressure();
    test_zero_beats();
    test_error();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
